// File: rtl/pc_pkg.sv
// pc_pkg: hold-flag encodings, PC generator state enum and alignment helper.
package pc_pkg;
  localparam logic [1:0] HOLD_RUN   = 2'b00;
  localparam logic [1:0] HOLD_FLUSH = 2'b01;
  localparam logic [1:0] HOLD_STALL = 2'b10;
  typedef enum logic [1:0] {BOOT, RUN, BUBBLE, WAIT_TRAP} state_e;
  function automatic int inst_shift(input int inst_bytes);
    return (inst_bytes == 2) ? 1 : 2;
  endfunction
endpackage

// File: rtl/pc_dff.sv
// pc_dff: width-parametrised register with async active-low reset to RST_VAL and load enable.
module pc_dff #(
  parameter int             W       = 64,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= RST_VAL;
    else if (en) q <= d;
endmodule

// File: rtl/pc_gen.sv
// pc_gen: RV64 fetch PC generator with valid/ready handshake, trap/jump redirect and epoch tag.
// Define PC_MISALIGN_CHK_EN to trap misaligned jump targets instead of silently aligning them.
module pc_gen
  import pc_pkg::*;
#(
  parameter int               XLEN         = 64,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter int               INST_BYTES   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_en_i,
  input  logic [XLEN-1:0] trap_addr_i,
  input  logic            jump_en_i,
  input  logic [XLEN-1:0] jump_addr_i,
  input  logic [1:0]      hold_flag_i,
  input  logic            fetch_ready_i,
  output logic            fetch_valid_o,
  output logic [XLEN-1:0] inst_addr_o,
  output logic            epoch_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] bad_addr_o
);
  localparam int              SH      = inst_shift(INST_BYTES);
  localparam logic [XLEN-1:0] ALIGN_M = XLEN'((64'd1 << SH) - 64'd1);
  localparam logic [XLEN-1:0] STEP    = XLEN'(INST_BYTES);
  state_e state_q, state_d;
  logic valid_q, valid_d, epoch_q, epoch_d, misalign_q, misalign_d, pc_en, bad_en;
  logic [XLEN-1:0] pc_q, pc_d, bad_d;
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    epoch_d    = epoch_q;
    misalign_d = 1'b0;
    pc_d       = pc_q;
    pc_en      = 1'b0;
    bad_d      = jump_addr_i;
    bad_en     = 1'b0;
    if (trap_en_i) begin
      pc_d    = trap_addr_i & ~ALIGN_M;
      pc_en   = 1'b1;
      epoch_d = ~epoch_q;
      state_d = RUN;
      valid_d = 1'b1;
    end else if (state_q == WAIT_TRAP) begin
      valid_d = 1'b0;
`ifdef PC_MISALIGN_CHK_EN
    end else if (jump_en_i && |(jump_addr_i & ALIGN_M)) begin
      bad_en     = 1'b1;
      misalign_d = 1'b1;
      valid_d    = 1'b0;
      state_d    = WAIT_TRAP;
`endif
    end else if (jump_en_i) begin
      pc_d    = jump_addr_i & ~ALIGN_M;
      pc_en   = 1'b1;
      epoch_d = ~epoch_q;
      state_d = RUN;
      valid_d = 1'b1;
    end else if (state_q != RUN) begin
      // BOOT and BUBBLE each last exactly one cycle, regardless of hold
      state_d = RUN;
      valid_d = 1'b1;
    end else if (hold_flag_i == HOLD_FLUSH) begin
      state_d = BUBBLE;
      valid_d = 1'b0;
    end else if (hold_flag_i == HOLD_RUN && valid_q && fetch_ready_i) begin
      pc_d  = pc_q + STEP;
      pc_en = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q    <= BOOT;
      valid_q    <= 1'b0;
      epoch_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      epoch_q    <= epoch_d;
      misalign_q <= misalign_d;
    end
  pc_dff #(.W(XLEN), .RST_VAL(RESET_VECTOR)) u_pc (
    .clk(clk), .rst(rst), .en(pc_en), .d(pc_d), .q(pc_q)
  );
`ifdef PC_MISALIGN_CHK_EN
  pc_dff #(.W(XLEN), .RST_VAL('0)) u_bad (
    .clk(clk), .rst(rst), .en(bad_en), .d(bad_d), .q(bad_addr_o)
  );
  assign misalign_o = misalign_q;
`else
  logic unused_ok;
  assign unused_ok  = ^{bad_en, bad_d, misalign_q};
  assign bad_addr_o = '0;
  assign misalign_o = 1'b0;
`endif
  assign fetch_valid_o = valid_q;
  assign inst_addr_o   = pc_q;
  assign epoch_o       = epoch_q;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: table-driven directed checks of pc_gen plus hand sequences for misalign and async reset.
module tb_pc_gen;
  typedef struct {
    logic        te;
    logic [63:0] ta;
    logic        je;
    logic [63:0] ja;
    logic [1:0]  hold;
    logic        rdy;
    logic        ev;
    logic [63:0] ea;
    logic        ep;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0;
  logic trap_en_i = 1'b0, jump_en_i = 1'b0, fetch_ready_i = 1'b0;
  logic [63:0] trap_addr_i = '0, jump_addr_i = '0;
  logic [1:0] hold_flag_i = 2'b00;
  logic fetch_valid_o, epoch_o, misalign_o;
  logic [63:0] inst_addr_o, bad_addr_o;
  int errors = 0, checks = 0;
  vec_t v[$];
  always #5 clk = ~clk;
  pc_gen #(.XLEN(64), .RESET_VECTOR(64'h1000), .INST_BYTES(4)) dut (
    .clk(clk), .rst(rst), .trap_en_i(trap_en_i), .trap_addr_i(trap_addr_i),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i), .hold_flag_i(hold_flag_i),
    .fetch_ready_i(fetch_ready_i), .fetch_valid_o(fetch_valid_o), .inst_addr_o(inst_addr_o),
    .epoch_o(epoch_o), .misalign_o(misalign_o), .bad_addr_o(bad_addr_o)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic add(input logic te, input logic [63:0] ta, input logic je, input logic [63:0] ja,
                     input logic [1:0] hold, input logic rdy, input logic ev, input logic [63:0] ea,
                     input logic ep);
    v.push_back('{te, ta, je, ja, hold, rdy, ev, ea, ep});
  endtask
  task automatic drive(input logic te, input logic [63:0] ta, input logic je, input logic [63:0] ja,
                       input logic [1:0] hold, input logic rdy);
    trap_en_i = te; trap_addr_i = ta; jump_en_i = je; jump_addr_i = ja;
    hold_flag_i = hold; fetch_ready_i = rdy;
  endtask
  initial begin
    add(0, 0, 0, 0, 2'b00, 1, 1, 64'h1000, 0);
    add(0, 0, 0, 0, 2'b00, 1, 1, 64'h1004, 0);
    add(0, 0, 0, 0, 2'b00, 1, 1, 64'h1008, 0);
    add(0, 0, 0, 0, 2'b00, 0, 1, 64'h1008, 0);
    add(0, 0, 1, 64'h8000, 2'b00, 0, 1, 64'h8000, 1);
    add(0, 0, 0, 0, 2'b00, 0, 1, 64'h8000, 1);
    add(1, 64'h200, 1, 64'h300, 2'b00, 1, 1, 64'h200, 0);
    add(0, 0, 0, 0, 2'b00, 1, 1, 64'h204, 0);
    add(0, 0, 0, 0, 2'b10, 1, 1, 64'h204, 0);
    add(0, 0, 0, 0, 2'b10, 1, 1, 64'h204, 0);
    add(0, 0, 0, 0, 2'b10, 1, 1, 64'h204, 0);
    add(0, 0, 0, 0, 2'b11, 1, 1, 64'h204, 0);
    add(0, 0, 0, 0, 2'b01, 1, 0, 64'h204, 0);
    add(0, 0, 0, 0, 2'b00, 1, 1, 64'h204, 0);
    add(0, 0, 0, 0, 2'b00, 1, 1, 64'h208, 0);
    add(1, 64'h303, 0, 0, 2'b00, 1, 1, 64'h300, 1);
    add(0, 0, 1, 64'h400, 2'b01, 1, 1, 64'h400, 0);
    add(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 2'b10, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1);
    add(0, 0, 0, 0, 2'b00, 1, 1, 64'h0, 1);
    add(0, 0, 0, 0, 2'b00, 1, 1, 64'h4, 1);
    #12;
    chk("reset_addr", inst_addr_o, 64'h1000);
    chk("reset_valid", 64'(fetch_valid_o), 64'h0);
    chk("reset_epoch", 64'(epoch_o), 64'h0);
    chk("reset_misalign", 64'(misalign_o), 64'h0);
    chk("reset_bad", bad_addr_o, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < v.size(); i++) begin
      drive(v[i].te, v[i].ta, v[i].je, v[i].ja, v[i].hold, v[i].rdy);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), 64'(fetch_valid_o), 64'(v[i].ev));
      chk($sformatf("v%0d_addr", i), inst_addr_o, v[i].ea);
      chk($sformatf("v%0d_epoch", i), 64'(epoch_o), 64'(v[i].ep));
      chk($sformatf("v%0d_misalign", i), 64'(misalign_o), 64'h0);
      @(negedge clk);
    end
    drive(0, 0, 1, 64'h8002, 2'b00, 1);
    @(posedge clk); #1;
`ifdef PC_MISALIGN_CHK_EN
    chk("mis_pulse", 64'(misalign_o), 64'h1);
    chk("mis_bad", bad_addr_o, 64'h8002);
    chk("mis_valid", 64'(fetch_valid_o), 64'h0);
    chk("mis_addr", inst_addr_o, 64'h4);
    chk("mis_epoch", 64'(epoch_o), 64'h1);
`else
    chk("jalign_pulse", 64'(misalign_o), 64'h0);
    chk("jalign_bad", bad_addr_o, 64'h0);
    chk("jalign_valid", 64'(fetch_valid_o), 64'h1);
    chk("jalign_addr", inst_addr_o, 64'h8000);
    chk("jalign_epoch", 64'(epoch_o), 64'h0);
`endif
    @(negedge clk);
    drive(0, 0, 1, 64'h9000, 2'b00, 1);
    @(posedge clk); #1;
`ifdef PC_MISALIGN_CHK_EN
    chk("wait_pulse", 64'(misalign_o), 64'h0);
    chk("wait_valid", 64'(fetch_valid_o), 64'h0);
    chk("wait_addr", inst_addr_o, 64'h4);
    chk("wait_bad", bad_addr_o, 64'h8002);
`else
    chk("j2_valid", 64'(fetch_valid_o), 64'h1);
    chk("j2_addr", inst_addr_o, 64'h9000);
    chk("j2_epoch", 64'(epoch_o), 64'h1);
`endif
    @(negedge clk);
    drive(1, 64'h100, 0, 0, 2'b00, 0);
    @(posedge clk); #1;
    chk("trap_exit_addr", inst_addr_o, 64'h100);
    chk("trap_exit_valid", 64'(fetch_valid_o), 64'h1);
    chk("trap_exit_epoch", 64'(epoch_o), 64'h0);
    @(negedge clk);
    drive(0, 0, 0, 0, 2'b00, 1);
    @(posedge clk); #1;
    chk("post_trap_adv", inst_addr_o, 64'h104);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_addr", inst_addr_o, 64'h1000);
    chk("async_rst_valid", 64'(fetch_valid_o), 64'h0);
    chk("async_rst_epoch", 64'(epoch_o), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("reboot_valid", 64'(fetch_valid_o), 64'h1);
    chk("reboot_addr", inst_addr_o, 64'h1000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
